memory_access_unit: RTL and testbench
=====================================

// Module: memory_access_unit
// PURPOSE
// - Responder side of the control_unit memory handshake (memory_*_enable -> memory_read_data_valid / memory_write_done).
// - Holds a word-organised data memory and serves one load or store at a time with fixed, parameterised latency.
// - Sits beside the register file and ALU; driven only by control_unit in the MEMORY_ACCESS state.
// PARAMETERS
// - DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 2
// - LATENCY      2     cycles from request acceptance to response pulse; legal 1..15
// PORTS
// - clk                     in   1   single clock, all state on rising edge
// - reset_n                 in   1   asynchronous, active-low reset
// - memory_read_enable      in   1   load request level, held by control_unit until response
// - memory_write_enable     in   1   store request level, held by control_unit until response
// - memory_address          in   32  byte address (ALU result)
// - memory_write_data       in   32  store data (rs2 value)
// - memory_read_data        out  32  load data; stable from read response until next read response
// - memory_read_data_valid  out  1   one-cycle pulse: load complete
// - memory_write_done       out  1   one-cycle pulse: store committed
// - mau_busy                out  1   high from acceptance through DRAIN exit
// BEHAVIOUR
// - Reset (async assert): memory_read_data=0, memory_read_data_valid=0, memory_write_done=0, mau_busy=0,
//   FSM=IDLE, counter=0; array contents not reset (undefined until written).
// - FSM: IDLE -> WAIT -> RESP -> DRAIN -> IDLE.
//   - IDLE: on edge with read or write enable high, latch address, write data and op;
//     counter=LATENCY-1; go WAIT (or RESP directly when LATENCY=1).
//   - WAIT: decrement counter each cycle; go RESP when counter reaches 1.
//   - RESP: present for exactly one cycle; registered outputs drive the pulse.
//     Response pulse is visible LATENCY cycles after the accepting edge.
//   - DRAIN: stay until both enables are low, then IDLE.
//     This prevents re-accepting the still-held enable on the cycle after the pulse.
// - Array index is memory_address[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
// - Store: array write commits on the same edge that raises memory_write_done. Read data is not modified.
// - Load: memory_read_data updates on the same edge that raises memory_read_data_valid. Data is read from the latched address.
// - Read-after-write to the same word returns the newly written data; no bypass is needed because the ops are serialised.
// - Both enables high at acceptance: treated as a store only; no read response is produced.
// - Enable dropped during WAIT: the request still completes and the pulse is still issued (requests are not cancellable).
// - Address or write-data change after acceptance: ignored.
// - Reset mid-operation: request aborted, no array write, no pulse after reset release.
// CONFIGURATION
// - MAU_ALIGN_CHECK_EN defined:
//   - Adds output memory_misaligned (1 bit, reset 0).
//   - If the latched address[1:0] != 0: response pulse at normal latency, and memory_misaligned pulses with it.
//   - Misaligned store: not committed.
//   - Misaligned load: returns 32'h0000_0000.
// - MAU_ALIGN_CHECK_EN undefined: no memory_misaligned port; address[1:0] ignored and the access goes to the containing word.
// TESTING
// - Reset: hold reset_n=0 with both enables high -> all outputs 0, mau_busy=0, no pulses.
// - Store/load: write 32'd12345 @ addr 204 -> write_done one cycle, exactly 2 cycles after accept.
//   Then read @ addr 204 -> read_data_valid pulse, read_data=12345.
// - Held enable: keep memory_read_enable high 3 cycles after the pulse -> exactly one response pulse; mau_busy falls one cycle after enable drops.
// - Wrap: DEPTH_WORDS=1024, write 32'hA5A5_0001 @ 0x0000_0010 -> read @ 0x0000_1010 returns 32'hA5A5_0001.
// - Both enables high, write_data=32'hDEAD_BEEF @ 8 -> only write_done pulses; later read @ 8 = 32'hDEAD_BEEF.
// - Reset mid-WAIT on a store of 32'h1 @ 12 (after a prior 32'h7 there): no pulse; read @ 12 returns 32'h7.
// - With MAU_ALIGN_CHECK_EN: store @ 0x0000_0005 -> write_done and memory_misaligned both pulse; word @ 4 unchanged.

Source files
------------

// File: rtl/memory_access_unit.sv
// memory_access_unit: fixed-latency word memory answering control_unit load/store handshakes
// Optional feature macro: MAU_ALIGN_CHECK_EN adds the memory_misaligned output and suppresses misaligned accesses.
module memory_access_unit #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        memory_read_enable,
   input  logic        memory_write_enable,
   input  logic [31:0] memory_address,
   input  logic [31:0] memory_write_data,
   output logic [31:0] memory_read_data,
   output logic        memory_read_data_valid,
   output logic        memory_write_done,
   output logic        mau_busy
`ifdef MAU_ALIGN_CHECK_EN
   ,
   output logic        memory_misaligned
`endif
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;
   state_t        state, state_nx;
   logic [3:0]    cnt, cnt_nx;
   logic [AW-1:0] idx;
   logic [31:0]   wdata;
   logic          is_write, mis, req, accept, resp;
   logic [31:0]   mem [DEPTH_WORDS];
   logic          unused_addr;
   assign unused_addr = ^{memory_address[31:AW+2], memory_address[1:0]};
   assign req         = memory_read_enable | memory_write_enable;
   assign accept      = state == IDLE && req;
   assign resp        = state == RESP;
   assign mau_busy    = state != IDLE;
   // next state: the response cycle lands LATENCY edges after acceptance, DRAIN waits out the held enables
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         IDLE: if (req) begin
            cnt_nx   = 4'(LATENCY - 1);
            state_nx = LATENCY == 1 ? RESP : WAIT;
         end
         WAIT: begin
            cnt_nx   = cnt - 4'd1;
            state_nx = cnt == 4'd1 ? RESP : WAIT;
         end
         RESP:    state_nx = DRAIN;
         DRAIN:   state_nx = req ? DRAIN : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   // state and latency counter; reset aborts any request in flight
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   // capture the request at acceptance so later input changes are ignored; write wins over read
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         idx      <= '0;
         wdata    <= '0;
         is_write <= 1'b0;
      end else if (accept) begin
         idx      <= memory_address[AW+1:2];
         wdata    <= memory_write_data;
         is_write <= memory_write_enable;
      end
`ifdef MAU_ALIGN_CHECK_EN
   // remember misalignment of the accepted address
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) mis <= 1'b0;
      else if (accept) mis <= |memory_address[1:0];
   // misalignment flag pulses alongside the response
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) memory_misaligned <= 1'b0;
      else memory_misaligned <= resp && mis;
`else
   assign mis = 1'b0;
`endif
   // response pulses and load data, all registered on the edge leaving RESP
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         memory_read_data       <= '0;
         memory_read_data_valid <= 1'b0;
         memory_write_done      <= 1'b0;
      end else begin
         memory_read_data_valid <= resp && !is_write;
         memory_write_done      <= resp && is_write;
         if (resp && !is_write) memory_read_data <= mis ? '0 : mem[idx];
      end
   // store commits on the same edge that raises memory_write_done
   always_ff @(posedge clk)
      if (resp && is_write && !mis) mem[idx] <= wdata;
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed load/store scenarios checked every cycle against a transaction-level model
module tb_memory_access_unit;
   localparam int L = 2;
`ifdef MAU_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif
   logic        clk = 1'b0, reset_n = 1'b1, rd_en = 1'b0, wr_en = 1'b0;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic        rvalid, wdone, busy, mis;
   int passed = 0, total = 0, cyc = 0;
   logic [31:0] mdl [int];
   bit          pend = 1'b0, p_wr = 1'b0, m_busy = 1'b0, prev_req = 1'b0;
   int          p_acc = 0, p_pulse = 0, resp_cyc = 0, last_acc = 0, last_drain = 0;
   logic [31:0] p_addr = '0, p_data = '0, m_rdata = '0;
   int          rd_pulses = 0, wr_pulses = 0, mis_pulses = 0, last_rv_cyc = 0, last_wd_cyc = 0;

   memory_access_unit #(.DEPTH_WORDS(1024), .LATENCY(L)) dut (
      .clk(clk), .reset_n(reset_n),
      .memory_read_enable(rd_en), .memory_write_enable(wr_en),
      .memory_address(addr), .memory_write_data(wdata),
      .memory_read_data(rdata), .memory_read_data_valid(rvalid),
      .memory_write_done(wdone), .mau_busy(busy)
`ifdef MAU_ALIGN_CHECK_EN
      , .memory_misaligned(mis)
`endif
   );
`ifndef MAU_ALIGN_CHECK_EN
   assign mis = 1'b0;
`endif

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // model: one outstanding op completes LATENCY edges after acceptance; busy lasts until enables are low after it
   always @(negedge clk) begin
      bit e_rv, e_wd, e_mis, bad;
      int i;
      e_rv = 1'b0; e_wd = 1'b0; e_mis = 1'b0;
      if (!reset_n) begin
         pend = 1'b0; m_busy = 1'b0; m_rdata = '0;
      end else begin
         if (pend && cyc == p_acc) m_busy = 1'b1;
         else if (m_busy && !pend && cyc > resp_cyc && !prev_req) m_busy = 1'b0;
         if (pend && cyc == p_pulse) begin
            i = int'((p_addr >> 2) % 1024);
            bad = ALIGN && p_addr[1:0] != 2'b00;
            e_mis = bad;
            if (p_wr) begin
               e_wd = 1'b1;
               if (!bad) mdl[i] = p_data;
            end else begin
               e_rv = 1'b1;
               m_rdata = bad ? 32'h0 : mdl[i];
            end
            pend = 1'b0;
            resp_cyc = cyc;
         end
      end
      prev_req = rd_en | wr_en;
      if (rvalid === 1'b1) begin rd_pulses++; last_rv_cyc = cyc; end
      if (wdone === 1'b1) begin wr_pulses++; last_wd_cyc = cyc; end
      if (mis === 1'b1) mis_pulses++;
      check("read_data_valid", 32'(rvalid), 32'(e_rv));
      check("write_done", 32'(wdone), 32'(e_wd));
      check("read_data", rdata, m_rdata);
      check("mau_busy", 32'(busy), 32'(m_busy));
      if (ALIGN) check("misaligned", 32'(mis), 32'(e_mis));
   end

   // issue one op; enables stay high for 'hold' edges counting the accepting edge
   task automatic do_op(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d, input int hold);
      int n;
      @(posedge clk); #1;
      wr_en = wr; rd_en = rd; addr = a; wdata = d;
      pend = 1'b1; p_wr = wr; p_addr = a; p_data = d;
      p_acc = cyc + 1; p_pulse = cyc + 1 + L; last_acc = cyc + 1;
      @(posedge clk); #1;
      addr = ~a; wdata = ~d;
      repeat (hold - 1) @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0;
      n = 0;
      while (busy && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      last_drain = n;
      check("busy_release", 32'(busy), 32'h0);
   endtask

   initial begin
      int rp, wp, mp;
      #2;
      reset_n = 1'b0; rd_en = 1'b1; wr_en = 1'b1; wdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_rvalid", 32'(rvalid), 32'h0);
      check("reset_wdone", 32'(wdone), 32'h0);
      rd_en = 1'b0; wr_en = 1'b0; reset_n = 1'b1;
      repeat (2) @(posedge clk);

      wp = wr_pulses;
      do_op(1, 0, 32'd204, 32'd12345, L + 1);
      check("store_pulses", 32'(wr_pulses - wp), 32'd1);
      check("store_latency", 32'(last_wd_cyc - last_acc), 32'd2);
      do_op(0, 1, 32'd204, 32'h0, L + 1);
      check("load_value", rdata, 32'd12345);
      check("load_latency", 32'(last_rv_cyc - last_acc), 32'd2);

      rp = rd_pulses;
      do_op(0, 1, 32'd204, 32'h0, L + 4);
      check("held_one_pulse", 32'(rd_pulses - rp), 32'd1);
      check("held_busy_fall", 32'(last_drain), 32'd1);

      do_op(1, 0, 32'h0000_0010, 32'hA5A5_0001, L + 1);
      do_op(0, 1, 32'h0000_1010, 32'h0, L + 1);
      check("wrap_value", rdata, 32'hA5A5_0001);

      rp = rd_pulses; wp = wr_pulses;
      do_op(1, 1, 32'd8, 32'hDEAD_BEEF, L + 1);
      check("both_no_read", 32'(rd_pulses - rp), 32'd0);
      check("both_write", 32'(wr_pulses - wp), 32'd1);
      do_op(0, 1, 32'd8, 32'h0, L + 1);
      check("both_value", rdata, 32'hDEAD_BEEF);

      wp = wr_pulses;
      do_op(1, 0, 32'd20, 32'h0000_0055, 1);
      check("drop_still_done", 32'(wr_pulses - wp), 32'd1);
      do_op(0, 1, 32'd20, 32'h0, L + 1);
      check("drop_value", rdata, 32'h0000_0055);

      do_op(1, 0, 32'd12, 32'h7, L + 1);
      wp = wr_pulses;
      @(posedge clk); #1;
      wr_en = 1'b1; addr = 32'd12; wdata = 32'h1;
      pend = 1'b1; p_wr = 1'b1; p_addr = 32'd12; p_data = 32'h1;
      p_acc = cyc + 1; p_pulse = cyc + 1 + L;
      @(posedge clk); #1;
      reset_n = 1'b0; wr_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      check("reset_abort_pulses", 32'(wr_pulses - wp), 32'd0);
      do_op(0, 1, 32'd12, 32'h0, L + 1);
      check("reset_abort_value", rdata, 32'h7);

      if (ALIGN) begin
         do_op(1, 0, 32'd4, 32'h1122_3344, L + 1);
         wp = wr_pulses; mp = mis_pulses;
         do_op(1, 0, 32'd5, 32'hFFFF_0000, L + 1);
         check("mis_done", 32'(wr_pulses - wp), 32'd1);
         check("mis_flag", 32'(mis_pulses - mp), 32'd1);
         do_op(0, 1, 32'd4, 32'h0, L + 1);
         check("mis_unchanged", rdata, 32'h1122_3344);
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, total);
      $fatal(1, "watchdog");
   end
endmodule
